// File: rtl/opendap_swd_link_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | opendap_swd_link_sequencer_if : command handshake and serial pad bundle    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface opendap_swd_link_sequencer_if;
  logic       req_valid;
  logic [1:0] req_op;
  logic       req_ready;
  logic       swdo;
  logic       swdo_oe;
  logic       busy;
  logic       done;

  modport master (
    output req_valid, req_op,
    input  req_ready, swdo, swdo_oe, busy, done
  );

  modport slave (
    input  req_valid, req_op,
    output req_ready, swdo, swdo_oe, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/opendap_swd_link_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | opendap_swd_link_sequencer : SWD line reset / dormant entry & exit streams |
// | Optional post-sequence idle tail: OPENDAP_SWD_SEQ_TAIL_EN.  Rev 1.0        |
// +----------------------------------------------------------------------------+
module opendap_swd_link_sequencer #(
  parameter int unsigned N_PRE_ONES   = 8,
  parameter int unsigned N_RESET_ONES = 50
) (
  input wire                          swclk,
  input wire                          rst_n,
  opendap_swd_link_sequencer_if.slave bus
);

  localparam logic [1:0]  C_OP_LINE_RESET    = 2'd0;
  localparam logic [1:0]  C_OP_EXIT_DORMANT  = 2'd1;
  localparam logic [1:0]  C_OP_ENTER_DORMANT = 2'd2;
  localparam logic [7:0]  C_PRE_LOAD         = 8'(N_PRE_ONES - 1);
  localparam logic [7:0]  C_RST_LOAD         = 8'(N_RESET_ONES - 1);
  localparam logic [6:0]  C_LFSR_SEED        = 7'b1001001;
  localparam logic [6:0]  C_LFSR_TAPS        = 7'b1001011;
  localparam logic [7:0]  C_ACT_CODE         = 8'b01011000;
  localparam logic [15:0] C_S2D_SELECT       = 16'b0011110111000111;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_PRE_ONES    = 4'd1,
    S_ALERT_START = 4'd2,
    S_ALERT       = 4'd3,
    S_POST_ALERT  = 4'd4,
    S_ACT_CODE    = 4'd5,
    S_RST_ONES    = 4'd6,
    S_RST_LOW     = 4'd7,
    S_S2D_SELECT  = 4'd8,
    S_TAIL        = 4'd9
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic       dormant_q, dormant_d;
  logic       swdo_q, swdo_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       accept;
  logic       last;
  logic       seq_end;
  logic [7:0] cnt_dec;

  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      lfsr_q    <= C_LFSR_SEED;
      dormant_q <= 1'b0;
      swdo_q    <= 1'b0;
      oe_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      dormant_q <= dormant_d;
      swdo_q    <= swdo_d;
      oe_q      <= oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Each state emits the bit for the current count; the output registers
  // therefore trail the state register by exactly one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    dormant_d = dormant_q;
    swdo_d    = 1'b0;
    oe_d      = 1'b0;
    done_d    = 1'b0;
    seq_end   = 1'b0;
    accept    = bus.req_valid && ready_q;
    last      = (cnt_q == 8'd0);
    cnt_dec   = cnt_q - 8'd1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            C_OP_LINE_RESET: begin
              state_d   = S_RST_ONES;
              cnt_d     = C_RST_LOAD;
              dormant_d = 1'b0;
            end
            C_OP_EXIT_DORMANT: begin
              state_d   = S_PRE_ONES;
              cnt_d     = C_PRE_LOAD;
              dormant_d = 1'b0;
            end
            C_OP_ENTER_DORMANT: begin
              state_d   = S_RST_ONES;
              cnt_d     = C_RST_LOAD;
              dormant_d = 1'b1;
            end
            default: done_d = 1'b1;
          endcase
        end
      end
      S_PRE_ONES: begin
        oe_d   = 1'b1;
        swdo_d = 1'b1;
        if (last) begin
          state_d = S_ALERT_START;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_ALERT_START: begin
        oe_d    = 1'b1;
        lfsr_d  = C_LFSR_SEED;
        state_d = S_ALERT;
        cnt_d   = 8'd126;
      end
      S_ALERT: begin
        oe_d   = 1'b1;
        swdo_d = lfsr_q[0];
        lfsr_d = {^(lfsr_q & C_LFSR_TAPS), lfsr_q[6:1]};
        if (last) begin
          state_d = S_POST_ALERT;
          cnt_d   = 8'd3;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_POST_ALERT: begin
        oe_d = 1'b1;
        if (last) begin
          state_d = S_ACT_CODE;
          cnt_d   = 8'd7;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_ACT_CODE: begin
        oe_d   = 1'b1;
        swdo_d = C_ACT_CODE[cnt_q[2:0]];
        if (last) begin
          state_d   = S_RST_ONES;
          cnt_d     = C_RST_LOAD;
          dormant_d = 1'b0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RST_ONES: begin
        oe_d   = 1'b1;
        swdo_d = 1'b1;
        if (last) begin
          state_d = dormant_q ? S_S2D_SELECT : S_RST_LOW;
          cnt_d   = dormant_q ? 8'd15 : 8'd1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      S_RST_LOW: begin
        oe_d = 1'b1;
        if (last) seq_end = 1'b1;
        else      cnt_d   = cnt_dec;
      end
      S_S2D_SELECT: begin
        oe_d   = 1'b1;
        swdo_d = C_S2D_SELECT[cnt_q[3:0]];
        if (last) seq_end = 1'b1;
        else      cnt_d   = cnt_dec;
      end
      S_TAIL: begin
        oe_d = 1'b1;
        if (last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (seq_end) begin
`ifdef OPENDAP_SWD_SEQ_TAIL_EN
      state_d = S_TAIL;
      cnt_d   = 8'd1;
`else
      state_d = S_IDLE;
      done_d  = 1'b1;
`endif
    end

    // Busy spans the accept cycle through the done cycle, so it is raised on
    // accept and held while the state register is still away from IDLE.
    busy_d  = accept || (state_q != S_IDLE);
    ready_d = !busy_d;
  end

  assign bus.req_ready = ready_q;
  assign bus.swdo      = swdo_q;
  assign bus.swdo_oe   = oe_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
`default_nettype wire
